// File: rtl/croc_addr_decoder_cfg_pkg.sv
// -----------------------------------------------------------------------------
// croc_addr_decoder_cfg_pkg
// Shared types and constants for the runtime-programmable address decoder:
//   addr_map_rule_t   one address rule {idx, start_addr, end_addr}
//   reg_req_t/rsp_t   config regbus request / response
//   addr_dec_state_e  commit sequencer states {IDLE, DRAIN, APPLY}
//   periph_addr_map   static peripheral map, used as the rule table reset value
//   apply_wstrb       byte-strobe merge for 32-bit register writes
// -----------------------------------------------------------------------------
package croc_addr_decoder_cfg_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    APPLY
  } addr_dec_state_e;

  // Register map (byte offsets on the config port)
  localparam int unsigned AddrDecRuleStride   = 16;
  localparam logic [31:0] AddrDecIdxOffset    = 32'h0;
  localparam logic [31:0] AddrDecStartOffset  = 32'h4;
  localparam logic [31:0] AddrDecEndOffset    = 32'h8;
  localparam logic [31:0] AddrDecCtrlOffset   = 32'h100;
  localparam logic [31:0] AddrDecStatusOffset = 32'h104;

  // Peripheral subordinate indices
  localparam logic [31:0] PeriphError   = 32'd0;
  localparam logic [31:0] PeriphDebug   = 32'd1;
  localparam logic [31:0] PeriphSocCtrl = 32'd2;
  localparam logic [31:0] PeriphUart    = 32'd3;
  localparam logic [31:0] PeriphGpio    = 32'd4;
  localparam logic [31:0] PeriphTimer   = 32'd5;

  localparam int unsigned PeriphNumRules = 5;

  // Positional pattern: leftmost entry is rule 4, rightmost is rule 0.
  localparam addr_map_rule_t [PeriphNumRules-1:0] periph_addr_map = '{
    '{idx: PeriphTimer,   start_addr: 32'h0300_A000, end_addr: 32'h0300_B000},
    '{idx: PeriphGpio,    start_addr: 32'h0300_5000, end_addr: 32'h0300_6000},
    '{idx: PeriphUart,    start_addr: 32'h0300_2000, end_addr: 32'h0300_3000},
    '{idx: PeriphSocCtrl, start_addr: 32'h0300_0000, end_addr: 32'h0300_1000},
    '{idx: PeriphDebug,   start_addr: 32'h0000_0000, end_addr: 32'h0004_0000}
  };

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/croc_addr_decoder_cfg_match.sv
// -----------------------------------------------------------------------------
// croc_addr_rule_match
// Combinational priority matcher: returns the index of the lowest-numbered rule
// whose half-open range [start_addr, end_addr) contains addr. A rule whose
// start_addr >= end_addr never matches. No match -> DefaultIdx with hit=0.
// Ports:
//   rules  in   addr_map_rule_t [NumRules]  rule table
//   addr   in   32                          address to look up
//   idx    out  IdxWidth                    matched index (truncated)
//   hit    out  1                           a rule matched
// -----------------------------------------------------------------------------
module croc_addr_rule_match
  import croc_addr_decoder_cfg_pkg::*;
#(
  parameter int unsigned NumRules   = 5,
  parameter int unsigned IdxWidth   = 3,
  parameter int unsigned DefaultIdx = 0
) (
  input  addr_map_rule_t [NumRules-1:0] rules,
  input  logic [31:0]                   addr,
  output logic [IdxWidth-1:0]           idx,
  output logic                          hit
);

  logic [NumRules-1:0] rule_hit;
  logic                unused_idx_bits;

  always_comb begin
    rule_hit = '0;
    for (int unsigned r = 0; r < NumRules; r++) begin
      rule_hit[r] = (rules[r].start_addr < rules[r].end_addr) &&
                    (addr >= rules[r].start_addr) &&
                    (addr <  rules[r].end_addr);
    end
  end

  // Walk from the highest rule down so the lowest matching rule is assigned last.
  always_comb begin
    idx = IdxWidth'(DefaultIdx);
    hit = 1'b0;
    for (int unsigned r = NumRules; r > 0; r--) begin
      if (rule_hit[r-1]) begin
        idx = rules[r-1].idx[IdxWidth-1:0];
        hit = 1'b1;
      end
    end
  end

  // Index bits above IdxWidth are dropped by design.
  always_comb begin
    unused_idx_bits = 1'b0;
    for (int unsigned r = 0; r < NumRules; r++) begin
      unused_idx_bits = unused_idx_bits ^ (^rules[r].idx);
    end
  end

endmodule

// File: rtl/croc_addr_decoder_cfg.sv
// -----------------------------------------------------------------------------
// croc_addr_decoder_cfg
// Runtime-programmable address decoder. NumRules rules live in regbus-writable
// shadow registers; a COMMIT waits for the output register to drain, then copies
// shadow into the active set in one cycle. Decoding uses the active set only and
// has one output register (latency 1, full throughput).
// Optional feature: define CROC_ADDR_DECODER_LOCK_EN to implement CTRL.LOCK,
// which freezes the rule table and CTRL until reset.
// Ports:
//   clk_i        in   1          clock
//   rst_i        in   1          synchronous active-high reset
//   reg_req_i    in   reg_req_t  config regbus request
//   reg_rsp_o    out  reg_rsp_t  config regbus response (always ready)
//   dec_valid_i  in   1          decode request valid
//   dec_ready_o  out  1          decode request accepted
//   dec_addr_i   in   32         address to decode
//   dec_valid_o  out  1          decode result valid
//   dec_ready_i  in   1          result consumed
//   dec_idx_o    out  IdxWidth   matched subordinate index
//   dec_hit_o    out  1          rule matched (0 = DefaultIdx)
// Register map: 0x00+16*r IDX, +4 START, +8 END (shadow, R/W);
//   0x100 CTRL bit0 COMMIT (W1, reads 0), bit1 LOCK (W1S);
//   0x104 STATUS (RO) bit0 commit_pending, bit1 lock.
// -----------------------------------------------------------------------------
module croc_addr_decoder_cfg
  import croc_addr_decoder_cfg_pkg::*;
#(
  parameter int unsigned                    NumRules   = PeriphNumRules,
  parameter int unsigned                    IdxWidth   = 3,
  parameter int unsigned                    DefaultIdx = 0,
  parameter addr_map_rule_t [NumRules-1:0]  ResetMap   = periph_addr_map,
  parameter type                            reg_req_t  = croc_addr_decoder_cfg_pkg::reg_req_t,
  parameter type                            reg_rsp_t  = croc_addr_decoder_cfg_pkg::reg_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  reg_req_t            reg_req_i,
  output reg_rsp_t            reg_rsp_o,
  input  logic                dec_valid_i,
  output logic                dec_ready_o,
  input  logic [31:0]         dec_addr_i,
  output logic                dec_valid_o,
  input  logic                dec_ready_i,
  output logic [IdxWidth-1:0] dec_idx_o,
  output logic                dec_hit_o
);

  localparam int unsigned RuleSelW = (NumRules > 1) ? $clog2(NumRules) : 1;

  addr_map_rule_t [NumRules-1:0] shadow_q;
  addr_map_rule_t [NumRules-1:0] active_q;

  addr_dec_state_e state_q, state_d;

  logic                dec_valid_q;
  logic [IdxWidth-1:0] dec_idx_q;
  logic                dec_hit_q;

  logic [IdxWidth-1:0] match_idx;
  logic                match_hit;

  logic                lock;
  logic                pending;
  logic                accept_en;
  logic                apply_en;

  logic [31:0]         offset;
  logic                is_rule;
  logic                is_ctrl;
  logic                is_status;
  logic [RuleSelW-1:0] rule_sel;
  logic [1:0]          rule_field;
  logic                wr_rule;
  logic                wr_ctrl;
  logic                reg_err;
  logic [31:0]         reg_rdata;
  logic                commit_req;

  // ---------------------------------------------------------------------------
  // Regbus address decode and response (single-cycle, always ready)
  // ---------------------------------------------------------------------------
  assign offset     = reg_req_i.addr;
  assign rule_sel   = offset[4 +: RuleSelW];
  assign rule_field = offset[3:2];
  assign is_rule    = (offset < NumRules * AddrDecRuleStride) &&
                      (rule_field != 2'd3) && (offset[1:0] == 2'b00);
  assign is_ctrl    = (offset == AddrDecCtrlOffset);
  assign is_status  = (offset == AddrDecStatusOffset);

  always_comb begin
    wr_rule   = 1'b0;
    wr_ctrl   = 1'b0;
    reg_err   = 1'b0;
    reg_rdata = '0;
    if (reg_req_i.valid) begin
      if (is_rule) begin
        if (reg_req_i.write) begin
          if (lock) reg_err = 1'b1;
          else      wr_rule = 1'b1;
        end else begin
          case (rule_field)
            2'd0:    reg_rdata = shadow_q[rule_sel].idx;
            2'd1:    reg_rdata = shadow_q[rule_sel].start_addr;
            2'd2:    reg_rdata = shadow_q[rule_sel].end_addr;
            default: reg_rdata = '0;
          endcase
        end
      end else if (is_ctrl) begin
        if (reg_req_i.write) begin
          if (lock) reg_err = 1'b1;
          else      wr_ctrl = 1'b1;
        end else begin
          reg_rdata = {30'b0, lock, 1'b0};
        end
      end else if (is_status) begin
        if (reg_req_i.write) reg_err = 1'b1;
        else                 reg_rdata = {30'b0, lock, pending};
      end else begin
        reg_err = 1'b1;
      end
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = reg_err;
    reg_rsp_o.rdata = reg_err ? '0 : reg_rdata;
  end

  assign commit_req = wr_ctrl && reg_req_i.wstrb[0] && reg_req_i.wdata[0];

  // ---------------------------------------------------------------------------
  // Optional table lock
  // ---------------------------------------------------------------------------
`ifdef CROC_ADDR_DECODER_LOCK_EN
  logic lock_q;
  logic lock_set;

  assign lock_set = wr_ctrl && reg_req_i.wstrb[0] && reg_req_i.wdata[1];

  always_ff @(posedge clk_i) begin
    if (rst_i)         lock_q <= 1'b0;
    else if (lock_set) lock_q <= 1'b1;
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Shadow and active rule tables
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= ResetMap;
    end else if (wr_rule) begin
      case (rule_field)
        2'd0: shadow_q[rule_sel].idx <=
                apply_wstrb(shadow_q[rule_sel].idx, reg_req_i.wdata, reg_req_i.wstrb);
        2'd1: shadow_q[rule_sel].start_addr <=
                apply_wstrb(shadow_q[rule_sel].start_addr, reg_req_i.wdata, reg_req_i.wstrb);
        2'd2: shadow_q[rule_sel].end_addr <=
                apply_wstrb(shadow_q[rule_sel].end_addr, reg_req_i.wdata, reg_req_i.wstrb);
        default: ;
      endcase
    end
  end

  // A shadow write in the APPLY cycle is not captured here: active_q samples
  // the pre-write shadow value, so that write waits for the next commit.
  always_ff @(posedge clk_i) begin
    if (rst_i)         active_q <= ResetMap;
    else if (apply_en) active_q <= shadow_q;
  end

  // ---------------------------------------------------------------------------
  // Commit sequencer: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_req) state_d = DRAIN;
      DRAIN:   if (!dec_valid_q || dec_ready_i) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending   = (state_q != IDLE);
    accept_en = (state_q == IDLE);
    apply_en  = (state_q == APPLY);
  end

  // ---------------------------------------------------------------------------
  // Decode path: priority match on the active set, one output register
  // ---------------------------------------------------------------------------
  croc_addr_rule_match #(
    .NumRules   (NumRules),
    .IdxWidth   (IdxWidth),
    .DefaultIdx (DefaultIdx)
  ) i_match (
    .rules (active_q),
    .addr  (dec_addr_i),
    .idx   (match_idx),
    .hit   (match_hit)
  );

  assign dec_ready_o = (!dec_valid_q || dec_ready_i) && accept_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_valid_q <= 1'b0;
      dec_idx_q   <= IdxWidth'(DefaultIdx);
      dec_hit_q   <= 1'b0;
    end else if (dec_valid_i && dec_ready_o) begin
      dec_valid_q <= 1'b1;
      dec_idx_q   <= match_idx;
      dec_hit_q   <= match_hit;
    end else if (dec_ready_i) begin
      dec_valid_q <= 1'b0;
    end
  end

  assign dec_valid_o = dec_valid_q;
  assign dec_idx_o   = dec_idx_q;
  assign dec_hit_o   = dec_hit_q;

endmodule
